alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU; next generation of the combinational datapath ALU.
//  Adds iterative unsigned multiply and divide, shifts, and a valid/ready handshake
//  on both sides. Result and status byte are registered.
//  Sits between decode/issue and writeback; the issue stage stalls on in_ready.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be >=4 and a power of two
//  SH_W   $clog2(WIDTH)  shift-amount width; derived, do not override
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      operation request valid
//  in_ready       out  1      ALU can accept; high only in IDLE
//  alu_ctrl       in   4      opcode, see BEHAVIOUR
//  alu_operand_1  in   WIDTH  operand A
//  alu_operand_2  in   WIDTH  operand B
//  shamnt         in   SH_W   shift amount for SLL/SRL
//  out_valid      out  1      result/status valid
//  out_ready      in   1      consumer takes result
//  alu_result     out  WIDTH  registered result
//  alu_status     out  8      [7]zero [6]ovf [5]carry [4]neg [3]odd [2]div0 [1:0]=0
//  busy           out  1      high in MUL/DIV iteration states
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; busy=0;
//   alu_result=0; alu_status=0. Reset mid-operation aborts and discards work in flight.
//  Opcodes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLTU (A<B unsigned -> 1 else 0),
//   1100 NOR, 1010 XOR, 1110 SLL A<<shamnt, 1111 SRL A>>shamnt (logical),
//   1000 MULU (low WIDTH bits of A*B), 1001 DIVU (quotient A/B). Others -> result 0.
//  Operands, opcode and shamnt are captured on the accepting edge (in_valid&&in_ready).
//   Inputs may change after that edge.
//  FSM: IDLE -> DONE for single-cycle ops and for DIVU with B==0; IDLE -> MUL or DIV
//   otherwise; MUL/DIV -> DONE after exactly WIDTH iteration cycles;
//   DONE -> IDLE on out_ready.
//  Latency: single-cycle ops, out_valid high in the cycle after acceptance.
//   MULU/DIVU, out_valid high WIDTH+1 cycles after acceptance.
//  MULU: shift-add, 1 bit/cycle, 2*WIDTH product. DIVU: restoring, 1 quotient bit/cycle.
//  DIVU with B==0: result={WIDTH{1}}, status[2]=1, 1-cycle latency, no iteration.
//  Handshake: result transfers on edge with out_valid&&out_ready. alu_result and
//   alu_status are held stable while out_valid&&!out_ready. in_ready=0 in MUL/DIV/DONE.
//   Back-to-back single-cycle throughput is 1 op per 2 cycles.
//  Status, computed from the final result; all flags 0 when out_valid=0 after reset:
//   zero: result==0.
//   ovf: ADD same-sign operands with result sign differing; SUB opposite-sign operands
//    with result sign != A sign; MULU high half of product !=0; else 0.
//   carry: ADD carry-out of A+B; SUB carry-out of A+~B+1 (1 = no borrow); else 0.
//   neg: result[WIDTH-1]. odd: result[0].
//   div0: DIVU with B==0 only.
//  in_valid while in_ready=0 is ignored; the requester holds its request.
//  Simultaneous out_ready in DONE and in_valid: the new op is not accepted that cycle
//   (in_ready=0); it is accepted the next cycle in IDLE.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF+0x1 -> result 0x80000000, status 0x50, out_valid 1 cycle after accept
//  ADD 0xFFFFFFFF+0x1 -> result 0x0, status 0xA0; SUB 5-5 -> result 0x0, status 0xA0
//  MULU 0x00010000*0x00010000 -> result 0x0, status 0xC0, out_valid 33 cycles after
//   accept, busy=1 for 32 cycles
//  DIVU 100/7 -> result 0xE, status 0x00 after 33 cycles; DIVU 5/0 -> result 0xFFFFFFFF,
//   status 0x1C after 1 cycle
//  SRL 0x80000000 shamnt=31 -> result 0x1, status 0x08; hold out_ready=0 for 5 cycles ->
//   result/status unchanged, in_ready=0, new in_valid ignored
//  Assert rst_n=0 at cycle 10 of a MULU -> all outputs 0 and in_ready=1 immediately;
//   next ADD 2+3 after release -> result 0x5, status 0x08

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, iterative unsigned multiply/divide,
// registered result and status byte.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_operand_1,
  input  logic [WIDTH-1:0] alu_operand_2,
  input  logic [SH_W-1:0]  shamnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [7:0]       alu_status,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] hi, lo, b, r1, mul_hi, mul_lo, div_hi, div_lo, nh, nl;
  logic [SH_W-1:0] cnt;
  logic [WIDTH:0] add_s, sub_s, mul_s, div_sh, div_d;
  logic c1, v1, d1, ge;
  assign add_s = {1'b0, alu_operand_1} + {1'b0, alu_operand_2};
  assign sub_s = {1'b0, alu_operand_1} + {1'b0, ~alu_operand_2} + {{WIDTH{1'b0}}, 1'b1};
  assign d1 = alu_ctrl == 4'b1001 && alu_operand_2 == '0;
  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (alu_ctrl)
      4'b0010: begin
        r1 = add_s[WIDTH-1:0];
        c1 = add_s[WIDTH];
        v1 = alu_operand_1[WIDTH-1] == alu_operand_2[WIDTH-1] && r1[WIDTH-1] != alu_operand_1[WIDTH-1];
      end
      4'b0110: begin
        r1 = sub_s[WIDTH-1:0];
        c1 = sub_s[WIDTH];
        v1 = alu_operand_1[WIDTH-1] != alu_operand_2[WIDTH-1] && r1[WIDTH-1] != alu_operand_1[WIDTH-1];
      end
      4'b0000: r1 = alu_operand_1 & alu_operand_2;
      4'b0001: r1 = alu_operand_1 | alu_operand_2;
      4'b0111: r1 = {{(WIDTH-1){1'b0}}, alu_operand_1 < alu_operand_2};
      4'b1100: r1 = ~(alu_operand_1 | alu_operand_2);
      4'b1010: r1 = alu_operand_1 ^ alu_operand_2;
      4'b1110: r1 = alu_operand_1 << shamnt;
      4'b1111: r1 = alu_operand_1 >> shamnt;
      4'b1001: r1 = '1;
      default: r1 = '0;
    endcase
  end
  // Shift-add step: hi accumulates, multiplier bits retire out of lo as the product shifts in.
  assign mul_s  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
  assign mul_hi = mul_s[WIDTH:1];
  assign mul_lo = {mul_s[0], lo[WIDTH-1:1]};
  // Restoring step: hi is the partial remainder, lo trades dividend bits for quotient bits.
  assign div_sh = {hi, lo[WIDTH-1]};
  assign div_d  = div_sh - {1'b0, b};
  assign ge     = !div_d[WIDTH];
  assign div_hi = ge ? div_d[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo = {lo[WIDTH-2:0], ge};
  assign nh = state == MUL ? mul_hi : div_hi;
  assign nl = state == MUL ? mul_lo : div_lo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      alu_result <= '0;
      alu_status <= '0;
      hi         <= '0;
      lo         <= '0;
      b          <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          hi       <= '0;
          lo       <= alu_operand_1;
          b        <= alu_operand_2;
          cnt      <= '0;
          if (alu_ctrl == 4'b1000 || (alu_ctrl == 4'b1001 && !d1)) begin
            state <= alu_ctrl == 4'b1000 ? MUL : DIV;
            busy  <= 1'b1;
          end else begin
            state      <= DONE;
            out_valid  <= 1'b1;
            alu_result <= r1;
            alu_status <= {r1 == '0, v1, c1, r1[WIDTH-1], r1[0], d1, 2'b00};
          end
        end
        MUL, DIV: begin
          hi  <= nh;
          lo  <= nl;
          cnt <= cnt + 1'b1;
          if (cnt == SH_W'(WIDTH-1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            alu_result <= nl;
            alu_status <= {nl == '0, state == MUL && nh != '0, 1'b0, nl[WIDTH-1], nl[0], 3'b000};
          end
        end
        default: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [3:0] alu_ctrl = '0;
  logic [W-1:0] a = '0, b = '0, alu_result;
  logic [4:0] shamnt = '0;
  logic [7:0] alu_status;
  int checks = 0, errors = 0;
  logic [3:0] ops [12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100,
                           4'b1010, 4'b1110, 4'b1111, 4'b1000, 4'b1001, 4'b0011};

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .alu_operand_1(a), .alu_operand_2(b), .shamnt(shamnt),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .alu_status(alu_status), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] x, y, input logic [4:0] s,
                                output logic [31:0] r, output logic [7:0] st);
    logic [63:0] p;
    logic ovf, cy, d0;
    ovf = 1'b0; cy = 1'b0; d0 = 1'b0;
    p = 64'(x) * 64'(y);
    case (op)
      4'b0010: begin r = x + y; ovf = (x[31] == y[31]) && (r[31] != x[31]); cy = ((64'(x) + 64'(y)) >> 32) != 0; end
      4'b0110: begin r = x - y; ovf = (x[31] != y[31]) && (r[31] != x[31]); cy = x >= y; end
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0111: r = (x < y) ? 32'd1 : 32'd0;
      4'b1100: r = ~(x | y);
      4'b1010: r = x ^ y;
      4'b1110: r = x << s;
      4'b1111: r = x >> s;
      4'b1000: begin r = p[31:0]; ovf = p[63:32] != 0; end
      4'b1001: if (y == 0) begin r = '1; d0 = 1'b1; end else r = x / y;
      default: r = '0;
    endcase
    st = {r == 0, ovf, cy, r[31], r[0], d0, 2'b00};
  endfunction

  // Issue one op, scramble inputs after acceptance, then measure latency, busy and outputs.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, y, input logic [4:0] s, input string tag);
    logic [31:0] er;
    logic [7:0] es;
    int n, lat, bc;
    bit multi;
    model(op, x, y, s, er, es);
    multi = op == 4'b1000 || (op == 4'b1001 && y != 0);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = op; a = x; b = y; shamnt = s;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = 4'($urandom); a = $urandom; b = $urandom; shamnt = 5'($urandom);
    lat = 1; bc = 0;
    while (!out_valid && lat < 100) begin
      bc += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), multi ? 64'd33 : 64'd1);
    chk({tag, " busy_cycles"}, 64'(bc), multi ? 64'd32 : 64'd0);
    chk({tag, " result"}, 64'(alu_result), 64'(er));
    chk({tag, " status"}, 64'(alu_status), 64'(es));
    chk({tag, " in_ready_low"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] x, y, hr;
    logic [7:0] hs;
    #12;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst result", 64'(alu_result), 64'd0);
    chk("rst status", 64'(alu_status), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, "add_ovf");
    chk("add_ovf const", 64'({alu_result, alu_status}), 64'h80000000_50);
    release_out("add_ovf");
    run_op(4'b0010, 32'hFFFFFFFF, 32'h1, 5'd0, "add_carry");
    chk("add_carry const", 64'({alu_result, alu_status}), 64'h00000000_A0);
    release_out("add_carry");
    run_op(4'b0110, 32'd5, 32'd5, 5'd0, "sub_eq");
    chk("sub_eq const", 64'({alu_result, alu_status}), 64'h00000000_A0);
    release_out("sub_eq");
    run_op(4'b1000, 32'h00010000, 32'h00010000, 5'd0, "mul_hi");
    chk("mul_hi const", 64'({alu_result, alu_status}), 64'h00000000_C0);
    release_out("mul_hi");
    run_op(4'b1001, 32'd100, 32'd7, 5'd0, "div");
    chk("div const", 64'({alu_result, alu_status}), 64'h0000000E_00);
    release_out("div");
    run_op(4'b1001, 32'd5, 32'd0, 5'd0, "div0");
    chk("div0 const", 64'({alu_result, alu_status}), 64'hFFFFFFFF_1C);
    release_out("div0");

    // Held result with a competing request, then DONE+in_valid must not accept in the same cycle.
    run_op(4'b1111, 32'h80000000, 32'h0, 5'd31, "srl");
    chk("srl const", 64'({alu_result, alu_status}), 64'h00000001_08);
    hr = alu_result; hs = alu_status;
    in_valid = 1'b1; alu_ctrl = 4'b0010; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold result", 64'(alu_result), 64'(hr));
      chk("hold status", 64'(alu_status), 64'(hs));
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk("hold out_valid", 64'(out_valid), 64'd1);
    end
    release_out("srl");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("late accept valid", 64'(out_valid), 64'd1);
    chk("late accept result", 64'({alu_result, alu_status}), 64'h00000002_00);
    release_out("late accept");

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b1000; a = 32'h12345; b = 32'h777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", 64'(alu_result), 64'd0);
    chk("abort status", 64'(alu_status), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'b0010, 32'd2, 32'd3, 5'd0, "post_rst");
    chk("post_rst const", 64'({alu_result, alu_status}), 64'h00000005_08);
    release_out("post_rst");

    for (int k = 0; k < 40; k++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom_range(0, 3);
        1: y = x;
        default: y = $urandom;
      endcase
      run_op(ops[$urandom_range(0, 11)], x, y, 5'($urandom), "rand");
      release_out("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
